sipo_shift_receiver: RTL and testbench
======================================

# sipo_shift_receiver

Serial-in, parallel-out receiver that reassembles words serialized LSB-first by the team's PISO shift register. It samples one qualified serial bit per clock and counts bits into a frame. Each completed word goes to a holding register offered through a valid/ready handshake. It sits at the far end of the serial link and feeds parallel consumers.

## Interface
- WIDTH, 4, payload bits per frame (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  serial bit qualifier; bit sampled only when 1
- in  input  1  serial data bit, LSB of word first
- data  output  WIDTH  received word (holding register)
- out_valid  output  1  data holds an unconsumed word
- out_ready  input  1  consumer accepts data
- busy  output  1  frame partially received (bit count ≠ 0)
- overflow  output  1  sticky: a completed word was dropped
- parity_err  output  1  sticky parity error flag (see Configuration)

## Operation
- Reset (rst=0, asynchronous): shift register, bit counter, data ← 0; out_valid, busy, overflow, parity_err ← 0; state ← RECV.
- States: RECV (payload bits, counter 0..WIDTH-1); PAR (parity bit, only with macro).
- RECV, in_valid=1: shift ← {in, shift[WIDTH-1:1]}; counter+1. in_valid=0: hold everything; gaps of any length allowed mid-frame.
- Word completion = edge sampling the WIDTH-th payload bit (without macro) or the parity bit (with macro). Counter wraps to 0, state → RECV.
- On completion: if out_valid=0, or out_valid=1 and out_ready=1 on the same edge, data ← assembled word, out_valid=1. Else word dropped, data unchanged, overflow ← 1.
- Handshake: transfer on edge with out_valid=1 and out_ready=1; out_valid clears after that edge unless a new word loads on the same edge. out_ready ignored while out_valid=0. data stable while out_valid=1 and not accepted.
- busy = (counter ≠ 0) or state=PAR.
- overflow and parity_err are sticky; cleared only by reset.
- Bit order: first sampled bit → data[0], WIDTH-th → data[WIDTH-1].

## Timing
- One bit per clock max; back-to-back frames with no idle cycles supported.
- Latency: data/out_valid update on the same edge that samples the last frame bit (registered, visible after that edge).
- Sustained throughput: one word per WIDTH cycles (WIDTH+1 with macro) when out_ready held 1.
- All outputs registered; no combinational path from in/in_valid/out_ready to any output.
- Reset mid-frame: partial word discarded; next sampled bit after release is data[0].

## Configuration
- SIPO_PARITY_EN defined: frame = WIDTH payload bits + 1 even-parity bit (XOR of all WIDTH+1 bits must be 0). State PAR samples the parity bit. Mismatch: parity_err ← 1 (sticky); word still delivered per the completion rules.
- Undefined: no PAR state; frame = WIDTH bits; parity_err tied 0.

## Test plan
- Reset: hold rst=0, toggle inputs -> data=0, out_valid=0, busy=0, overflow=0, parity_err=0.
- WIDTH=4, in_valid=1, bits 1,1,0,1 on consecutive edges -> after 4th edge data=4'b1011, out_valid=1; out_ready=1 one cycle -> out_valid=0.
- Same frame with in_valid=0 gaps of 3 cycles between bits -> data=4'b1011, busy=1 during gaps.
- out_ready=0, send 1011 then 0110 -> data stays 1011, overflow=1. Repeat with out_ready=1 on the completion edge of 0110 -> data=0110, out_valid=1, overflow=0.
- rst pulsed low after 2 bits of 0110, then bits 1,0,1,0 -> data=4'b0101, no residue.
- SIPO_PARITY_EN: bits 1,1,0,1 + parity 1 -> data=1011, parity_err=0; parity 0 -> parity_err=1, data=1011 delivered.

Source files
------------

// File: rtl/sipo_shift_receiver.sv
// LSB-first serial-to-parallel receiver with a valid/ready holding register.
// Define SIPO_PARITY_EN to append an even-parity bit to every frame.
module sipo_shift_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  output logic [WIDTH-1:0] data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;
  logic             done_s;
  logic [WIDTH-1:0] word_s;

`ifdef SIPO_PARITY_EN
  typedef enum logic [0:0] {RECV = 1'b0, PAR = 1'b1} state_e;

  state_e state_q, state_d;
  logic   par_bad_s;
  logic   parity_err_q, parity_err_d;

  // Even parity: payload plus parity bit must XOR to zero.
  function automatic logic parity_ok(input logic [WIDTH-1:0] word, input logic pbit);
    parity_ok = ~(^{pbit, word});
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RECV;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: the last payload bit hands over to the parity slot
  always_comb begin
    state_d = state_q;
    case (state_q)
      RECV: begin
        if (in_valid && (cnt_q == LAST)) state_d = PAR;
        else                             state_d = RECV;
      end
      PAR: begin
        if (in_valid) state_d = RECV;
        else          state_d = PAR;
      end
      default: state_d = RECV;
    endcase
  end

  // Receive datapath: shift payload in RECV, judge the frame in PAR
  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    done_s    = 1'b0;
    word_s    = shift_q;
    par_bad_s = 1'b0;
    case (state_q)
      RECV: begin
        if (in_valid) begin
          shift_d = {in, shift_q[WIDTH-1:1]};
          if (cnt_q == LAST) cnt_d = '0;
          else               cnt_d = cnt_q + CNT_ONE;
        end else begin
          shift_d = shift_q;
        end
      end
      PAR: begin
        if (in_valid) begin
          done_s    = 1'b1;
          par_bad_s = ~parity_ok(shift_q, in);
        end else begin
          done_s = 1'b0;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
    busy_d       = (cnt_d != '0) || (state_d == PAR);
    parity_err_d = parity_err_q | (done_s & par_bad_s);
  end

  // Sticky parity error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  // Receive datapath: the WIDTH-th payload bit completes the frame
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_s  = 1'b0;
    word_s  = shift_q;
    if (in_valid) begin
      shift_d = {in, shift_q[WIDTH-1:1]};
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_s = 1'b1;
        word_s = shift_d;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      shift_d = shift_q;
    end
    busy_d = (cnt_d != '0);
  end

  assign parity_err = 1'b0;
`endif

  // Holding register: a completed word may replace one being accepted on the same edge
  always_comb begin
    data_d      = data_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    if (done_s) begin
      if (!out_valid_q || out_ready) begin
        data_d      = word_s;
        out_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

  assign data      = data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sipo_shift_receiver.sv
// Self-checking bench for sipo_shift_receiver: delivered words are checked
// against a scoreboard queue filled as each frame is driven.
module tb_sipo_shift_receiver;

  localparam int WIDTH = 4;
`ifdef SIPO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in;
  logic [WIDTH-1:0] data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overflow;
  logic             parity_err;

  logic [WIDTH-1:0] exp_q[$];
  int               chk_cnt;
  int               pass_cnt;

  sipo_shift_receiver #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in         (in),
    .data       (data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every accepted word must match the oldest expected word.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_extra_word", 32'd1, 32'd0);
      else                   check("sb_data", data, exp_q.pop_front());
    end
  end

  // Drive one frame LSB first; gap idle cycles follow each non-final bit.
  task automatic send_word(input logic [WIDTH-1:0] w, input int gap, input bit bad_par,
                           input bit ready_last, input bit expect_load);
    logic b;
    for (int i = 0; i < NBITS; i++) begin
      if (i < WIDTH) b = w[i];
      else           b = (^w) ^ bad_par;
      if (i == NBITS - 1) begin
        if (ready_last)  out_ready = 1'b1;
        if (expect_load) exp_q.push_back(w);
      end
      in_valid = 1'b1;
      in       = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in       = 1'b0;
      if (i < NBITS - 1) begin
        repeat (gap) begin
          @(posedge clk); #1;
          check("busy_in_gap", busy, 32'd1);
        end
      end
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid  = k[0];
      in        = ~k[0];
      out_ready = k[1];
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    in        = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
  endtask

  initial begin
    chk_cnt   = 0;
    pass_cnt  = 0;
    in_valid  = 1'b0;
    in        = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    #2;
    do_reset();
    check("rst_data", data, 32'd0);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_overflow", overflow, 32'd0);
    check("rst_parity_err", parity_err, 32'd0);

    // Basic frame 1,1,0,1
    send_word(4'b1011, 0, 1'b0, 1'b0, 1'b1);
    check("basic_data", data, 32'hB);
    check("basic_out_valid", out_valid, 32'd1);
    check("basic_busy", busy, 32'd0);
    @(posedge clk); #1;
    check("hold_data", data, 32'hB);
    drain();
    check("accept_clears_valid", out_valid, 32'd0);

    // Same frame with three idle cycles between bits
    send_word(4'b1011, 3, 1'b0, 1'b0, 1'b1);
    check("gap_data", data, 32'hB);
    check("gap_out_valid", out_valid, 32'd1);
    drain();

    // Second word dropped while the first is still unconsumed
    send_word(4'b1011, 0, 1'b0, 1'b0, 1'b1);
    send_word(4'b0110, 0, 1'b0, 1'b0, 1'b0);
    check("ovf_data_kept", data, 32'hB);
    check("ovf_flag", overflow, 32'd1);
    check("ovf_out_valid", out_valid, 32'd1);
    drain();
    @(posedge clk); #1;
    check("ovf_sticky", overflow, 32'd1);

    // Accept and reload on the same edge: no drop
    do_reset();
    check("ovf_cleared_by_rst", overflow, 32'd0);
    send_word(4'b1011, 0, 1'b0, 1'b0, 1'b1);
    send_word(4'b0110, 0, 1'b0, 1'b1, 1'b1);
    check("reload_data", data, 32'h6);
    check("reload_out_valid", out_valid, 32'd1);
    check("reload_overflow", overflow, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("reload_consumed", out_valid, 32'd0);

    // Reset mid-frame discards the partial word
    in_valid = 1'b1; in = 1'b0;
    @(posedge clk); #1;
    in = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in = 1'b0;
    check("mid_busy", busy, 32'd1);
    rst = 1'b0;
    #2;
    check("mid_rst_busy", busy, 32'd0);
    rst = 1'b1;
    send_word(4'b0101, 0, 1'b0, 1'b0, 1'b1);
    check("mid_rst_data", data, 32'h5);
    drain();

    // Back-to-back frames with random gaps and the consumer always ready
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      send_word(WIDTH'($urandom), (n < 4) ? 0 : int'($urandom_range(0, 2)), 1'b0, 1'b1, 1'b1);
    end
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("b2b_overflow", overflow, 32'd0);

`ifdef SIPO_PARITY_EN
    send_word(4'b1011, 0, 1'b0, 1'b0, 1'b1);
    check("par_good_data", data, 32'hB);
    check("par_good_flag", parity_err, 32'd0);
    drain();
    send_word(4'b1011, 0, 1'b1, 1'b0, 1'b1);
    check("par_bad_data", data, 32'hB);
    check("par_bad_valid", out_valid, 32'd1);
    check("par_bad_flag", parity_err, 32'd1);
    drain();
    @(posedge clk); #1;
    check("par_sticky", parity_err, 32'd1);
`else
    check("parity_tied_low", parity_err, 32'd0);
`endif

    out_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("sb_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
